// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared widths and constants for the write-back register file
package regs_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         NUM_REGS = 2 ** ADDR_W_DEF;

endpackage

// File: rtl/regs_wb_stage.sv
// rtl/regs_wb_stage.sv - one-cycle write-back staging register with capture logic
module regs_wb_stage
    import regs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stg_v,
    output logic [ADDR_W-1:0] stg_addr,
    output logic [DATA_W-1:0] stg_data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    // Writes to register 0 are dropped here so they are never committed or counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_v    <= 1'b0;
            stg_addr <= '0;
            stg_data <= '0;
        end else begin
            stg_v    <= wr_en && (wr_addr != ZERO_ADDR);
            stg_addr <= wr_addr;
            stg_data <= wr_data;
        end
    end

endmodule

// File: rtl/regs_wb.sv
// rtl/regs_wb.sv - 32-entry register file with staged write-back, bypassed reads and write counter
module regs_wb
    import regs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Wt_addr,
    input  logic [DATA_W-1:0] Wt_data,
    input  logic [ADDR_W-1:0] R_addr_A,
    input  logic [ADDR_W-1:0] R_addr_B,
    input  logic [ADDR_W-1:0] Debug_addr,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic [DATA_W-1:0] Debug_data,
    output logic              wb_pending,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int                NREGS     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic              stg_v;
    logic [ADDR_W-1:0] stg_addr;
    logic [DATA_W-1:0] stg_data;

    // Entry 0 is hardwired to zero and therefore has no storage.
    logic [DATA_W-1:0] regs_q [1:NREGS-1];

    regs_wb_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (RegWrite),
        .wr_addr  (Wt_addr),
        .wr_data  (Wt_data),
        .stg_v    (stg_v),
        .stg_addr (stg_addr),
        .stg_data (stg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (stg_v && (stg_addr == ADDR_W'(i))) begin
                    regs_q[i] <= stg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (stg_v && (wr_count != {CNT_W{1'b1}})) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    // Staged data wins over the array so a write is visible the cycle after it is presented.
    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (a == ADDR_W'(i)) begin
                v = regs_q[i];
            end
        end
        if (stg_v && (stg_addr == a) && (a != ZERO_ADDR)) begin
            v = stg_data;
        end
        return v;
    endfunction

    always_comb begin
        rdata_A    = rd_port(R_addr_A);
        rdata_B    = rd_port(R_addr_B);
        Debug_data = rd_port(Debug_addr);
    end

    assign wb_pending = stg_v;

endmodule

// File: tb/tb_regs_wb.sv
// tb/tb_regs_wb.sv - directed self-checking bench for regs_wb
module tb_regs_wb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              RegWrite;
    logic [ADDR_W-1:0] wt_addr_drv;
    logic [ADDR_W-1:0] Wt_addr;
    logic [DATA_W-1:0] Wt_data;
    logic [ADDR_W-1:0] R_addr_A;
    logic [ADDR_W-1:0] R_addr_B;
    logic [ADDR_W-1:0] Debug_addr;
    logic [DATA_W-1:0] rdata_A;
    logic [DATA_W-1:0] rdata_B;
    logic [DATA_W-1:0] Debug_data;
    logic              wb_pending;
    logic [CNT_W-1:0]  wr_count;

    // MUX2T1_5 model feeding the write address
    logic              use_mux;
    logic              mux_s;
    logic [4:0]        mux_i0;
    logic [4:0]        mux_i1;
    logic [4:0]        mux_o;

    int n_vec = 0;
    int n_err = 0;

    assign mux_o   = mux_s ? mux_i1 : mux_i0;
    assign Wt_addr = use_mux ? mux_o : wt_addr_drv;

    always #5 clk = ~clk;

    regs_wb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWrite   (RegWrite),
        .Wt_addr    (Wt_addr),
        .Wt_data    (Wt_data),
        .R_addr_A   (R_addr_A),
        .R_addr_B   (R_addr_B),
        .Debug_addr (Debug_addr),
        .rdata_A    (rdata_A),
        .rdata_B    (rdata_B),
        .Debug_data (Debug_data),
        .wb_pending (wb_pending),
        .wr_count   (wr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sample();
        n_vec++;
        if (rdata_A !== 32'h0 || wb_pending !== 1'b0 || wr_count !== 4'd0) begin
            $display("FAIL reset_hold: rdata_A=%h wb_pending=%b wr_count=%0d required 0/0/0",
                     rdata_A, wb_pending, wr_count);
            n_err++;
        end
        tick();
        rst_n = 1'b1;
        R_addr_A = 5'd5;
        RegWrite = 1'b1; wt_addr_drv = 5'd5; Wt_data = 32'hDEADBEEF;
        tick();
        RegWrite = 1'b0;
        tick();
        sample();
        n_vec++;
        if (rdata_A !== 32'hDEADBEEF) begin
            $display("FAIL reset_prewrite: rdata_A=%h required deadbeef", rdata_A);
            n_err++;
        end
        // stage r6 then reset while it is still in flight
        tick();
        RegWrite = 1'b1; wt_addr_drv = 5'd6; Wt_data = 32'h00C0FFEE;
        tick();
        RegWrite = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (rdata_A !== 32'h0 || wr_count !== 4'd0 || wb_pending !== 1'b0) begin
            $display("FAIL reset_async: rdata_A=%h wr_count=%0d wb_pending=%b required 0/0/0",
                     rdata_A, wr_count, wb_pending);
            n_err++;
        end
        tick();
        rst_n = 1'b1;
        R_addr_B = 5'd6;
        tick();
        sample();
        n_vec++;
        if (rdata_B !== 32'h0 || wr_count !== 4'd0) begin
            $display("FAIL reset_discard: rdata_B(r6)=%h wr_count=%0d required 0/0", rdata_B, wr_count);
            n_err++;
        end
    endtask

    task automatic test_write_latency();
        tick();
        R_addr_A = 5'd3; Debug_addr = 5'd3;
        RegWrite = 1'b1; wt_addr_drv = 5'd3; Wt_data = 32'h12345678;
        sample();
        n_vec++;
        if (rdata_A !== 32'h0 || wb_pending !== 1'b0) begin
            $display("FAIL write_cycle_n: rdata_A=%h wb_pending=%b required 0/0", rdata_A, wb_pending);
            n_err++;
        end
        tick();
        RegWrite = 1'b0;
        sample();
        n_vec++;
        if (rdata_A !== 32'h12345678 || wb_pending !== 1'b1 || wr_count !== 4'd0) begin
            $display("FAIL write_bypass: rdata_A=%h wb_pending=%b wr_count=%0d required 12345678/1/0",
                     rdata_A, wb_pending, wr_count);
            n_err++;
        end
        tick();
        sample();
        n_vec++;
        if (Debug_data !== 32'h12345678 || wb_pending !== 1'b0 || wr_count !== 4'd1) begin
            $display("FAIL write_commit: Debug_data=%h wb_pending=%b wr_count=%0d required 12345678/0/1",
                     Debug_data, wb_pending, wr_count);
            n_err++;
        end
    endtask

    task automatic test_reg_zero();
        tick();
        R_addr_B = 5'd0;
        RegWrite = 1'b1; wt_addr_drv = 5'd0; Wt_data = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            sample();
            n_vec++;
            if (rdata_B !== 32'h0 || wb_pending !== 1'b0 || wr_count !== 4'd1) begin
                $display("FAIL reg_zero[%0d]: rdata_B=%h wb_pending=%b wr_count=%0d required 0/0/1",
                         c, rdata_B, wb_pending, wr_count);
                n_err++;
            end
        end
        RegWrite = 1'b0;
    endtask

    task automatic test_back_to_back();
        tick();
        R_addr_A = 5'd7;
        RegWrite = 1'b1; wt_addr_drv = 5'd7; Wt_data = 32'h11;
        tick();
        Wt_data = 32'h22;
        sample();
        n_vec++;
        if (rdata_A !== 32'h11) begin
            $display("FAIL b2b_n1: rdata_A=%h required 00000011", rdata_A);
            n_err++;
        end
        tick();
        RegWrite = 1'b0;
        sample();
        n_vec++;
        if (rdata_A !== 32'h22 || wb_pending !== 1'b1) begin
            $display("FAIL b2b_n2: rdata_A=%h wb_pending=%b required 00000022/1", rdata_A, wb_pending);
            n_err++;
        end
        tick();
        sample();
        n_vec++;
        if (rdata_A !== 32'h22 || wb_pending !== 1'b0 || wr_count !== 4'd3) begin
            $display("FAIL b2b_n3: rdata_A=%h wb_pending=%b wr_count=%0d required 00000022/0/3",
                     rdata_A, wb_pending, wr_count);
            n_err++;
        end
    endtask

    task automatic test_mux_addr();
        tick();
        use_mux = 1'b1; mux_i0 = 5'b01100; mux_i1 = 5'b00101;
        mux_s = 1'b0; RegWrite = 1'b1; Wt_data = 32'hA;
        tick();
        mux_s = 1'b1; Wt_data = 32'hB;
        tick();
        RegWrite = 1'b0;
        tick();
        use_mux = 1'b0;
        R_addr_A = 5'd12; R_addr_B = 5'd5;
        sample();
        n_vec++;
        if (rdata_A !== 32'hA || rdata_B !== 32'hB || wr_count !== 4'd5) begin
            $display("FAIL mux_addr: r12=%h r5=%h wr_count=%0d required 0000000a/0000000b/5",
                     rdata_A, rdata_B, wr_count);
            n_err++;
        end
    endtask

    task automatic test_saturation();
        tick();
        RegWrite = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wt_addr_drv = 5'(k + 1);
            Wt_data = 32'h100 + 32'(k);
            tick();
        end
        RegWrite = 1'b0;
        tick();
        R_addr_A = 5'd20; R_addr_B = 5'd1;
        sample();
        n_vec++;
        if (wr_count !== 4'd15) begin
            $display("FAIL saturation: wr_count=%0d required 15", wr_count);
            n_err++;
        end
        n_vec++;
        if (rdata_A !== 32'h113 || rdata_B !== 32'h100) begin
            $display("FAIL sat_data: r20=%h r1=%h required 00000113/00000100", rdata_A, rdata_B);
            n_err++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        RegWrite = 1'b0; wt_addr_drv = '0; Wt_data = '0;
        R_addr_A = 5'd5; R_addr_B = '0; Debug_addr = '0;
        use_mux = 1'b0; mux_s = 1'b0; mux_i0 = '0; mux_i1 = '0;
        test_reset();
        test_write_latency();
        test_reg_zero();
        test_back_to_back();
        test_mux_addr();
        test_saturation();
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
